// File: rtl/sram_init_bist.sv
// Sits between the AHB RAM controller and the SRAM macro: fills every word with FILL, optionally reads back and checks.
// busy rises one cycle after an accepted start (or is already high out of reset); when idle the macro port is a pass-through.
module sram_init_bist #(
  parameter int          AW            = 12,
  parameter logic [31:0] FILL          = 32'h0000_0000,
  parameter bit          INIT_ON_RESET = 1'b1,
  parameter bit          VERIFY        = 1'b1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [31:0]   c_DI,
  input  logic [31:0]   c_BEN,
  input  logic [AW-3:0] c_AD,
  input  logic          c_EN,
  input  logic          c_R_WB,
  output logic [31:0]   c_DO,
  output logic [31:0]   DI,
  output logic [31:0]   BEN,
  output logic [AW-3:0] AD,
  output logic          EN,
  output logic          R_WB,
  input  logic [31:0]   DO,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-3:0] fail_addr
);

  localparam int WAW = AW - 2;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CHK, S_END} state_t;
  localparam state_t RST_STATE = INIT_ON_RESET ? S_WR : S_IDLE;

  state_t         r_state, w_state_nxt;
  logic [WAW-1:0] r_cnt, w_cnt_nxt;
  logic           r_busy, r_done, r_fail;
  logic [WAW-1:0] r_fail_addr;
  logic           r_cmp_pend;
  logic [WAW-1:0] r_cmp_addr;
  logic           w_cnt_max, w_start_ok, w_mismatch;

  assign w_cnt_max  = &r_cnt;
  assign w_start_ok = (r_state == S_IDLE) && start;
  // Only the first mismatch is recorded; the sweep itself never stops early.
  assign w_mismatch = r_cmp_pend && (DO != FILL) && !r_fail;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    DI          = FILL;
    BEN         = '0;
    AD          = r_cnt;
    EN          = 1'b0;
    R_WB        = 1'b1;
    case (r_state)
      S_IDLE: begin
        DI   = c_DI;
        BEN  = c_BEN;
        AD   = c_AD;
        EN   = c_EN;
        R_WB = c_R_WB;
        if (start) begin
          w_state_nxt = S_WR;
          w_cnt_nxt   = '0;
        end
      end
      S_WR: begin
        EN        = 1'b1;
        R_WB      = 1'b0;
        BEN       = '1;
        w_cnt_nxt = r_cnt + WAW'(1);
        if (w_cnt_max) w_state_nxt = VERIFY ? S_RD : S_END;
      end
      S_RD: begin
        EN        = 1'b1;
        w_cnt_nxt = r_cnt + WAW'(1);
        if (w_cnt_max) w_state_nxt = S_CHK;
      end
      S_CHK:   w_state_nxt = S_END;
      S_END:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= RST_STATE;
      r_cnt       <= '0;
      r_busy      <= INIT_ON_RESET;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_cmp_pend  <= 1'b0;
      r_cmp_addr  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_cmp_pend <= (r_state == S_RD);
      r_cmp_addr <= r_cnt;
      if (w_start_ok) begin
        r_done <= 1'b0;
        r_fail <= 1'b0;
      end else begin
        if (r_state == S_END) r_done <= 1'b1;
        if (w_mismatch) begin
          r_fail      <= 1'b1;
          r_fail_addr <= r_cmp_addr;
        end
      end
    end
  end

  assign c_DO      = DO;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;

endmodule

// File: tb/tb_sram_init_bist.sv
// Bench for sram_init_bist: auto-init/verify instance with a fault-injecting macro model,
// plus a no-init/no-verify instance exercising pass-through and the start path.
module tb_sram_init_bist;
  localparam int          AW   = 6;
  localparam logic [31:0] FILL = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst_a, rst_b;
  logic [31:0] ca_di, ca_ben, cb_di, cb_ben;
  logic [3:0]  ca_ad, cb_ad;
  logic        ca_en, ca_rwb, cb_en, cb_rwb;
  logic [31:0] a_cdo, a_di, a_ben, a_do, b_cdo, b_di, b_ben, b_do;
  logic [3:0]  a_ad, a_faddr, b_ad, b_faddr;
  logic        a_en, a_rwb, a_start, a_busy, a_done, a_fail;
  logic        b_en, b_rwb, b_start, b_busy, b_done, b_fail;

  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic        stuck [16];
  int          log_addr [$];
  bit          log_rd   [$];

  typedef struct {
    logic [31:0] di;
    logic [31:0] ben;
    logic [3:0]  ad;
    logic        en;
    logic        rwb;
    logic [69:0] exp_bus;
    logic        chk_do;
    logic [31:0] exp_do;
  } vec_t;

  sram_init_bist #(.AW(AW), .FILL(FILL), .INIT_ON_RESET(1'b1), .VERIFY(1'b1)) u_a (
    .HCLK(clk), .HRESETn(rst_a), .c_DI(ca_di), .c_BEN(ca_ben), .c_AD(ca_ad),
    .c_EN(ca_en), .c_R_WB(ca_rwb), .c_DO(a_cdo), .DI(a_di), .BEN(a_ben), .AD(a_ad),
    .EN(a_en), .R_WB(a_rwb), .DO(a_do), .start(a_start), .busy(a_busy),
    .done(a_done), .fail(a_fail), .fail_addr(a_faddr)
  );

  sram_init_bist #(.AW(AW), .FILL(FILL), .INIT_ON_RESET(1'b0), .VERIFY(1'b0)) u_b (
    .HCLK(clk), .HRESETn(rst_b), .c_DI(cb_di), .c_BEN(cb_ben), .c_AD(cb_ad),
    .c_EN(cb_en), .c_R_WB(cb_rwb), .c_DO(b_cdo), .DI(b_di), .BEN(b_ben), .AD(b_ad),
    .EN(b_en), .R_WB(b_rwb), .DO(b_do), .start(b_start), .busy(b_busy),
    .done(b_done), .fail(b_fail), .fail_addr(b_faddr)
  );

  // Stuck words hold their contents but always read back as zero.
  always @(posedge clk) begin
    if (a_en && !a_rwb) mem_a[a_ad] <= (mem_a[a_ad] & ~a_ben) | (a_di & a_ben);
    if (a_en && a_rwb)  a_do <= stuck[a_ad] ? 32'h0 : mem_a[a_ad];
    if (rst_a && a_en) begin
      log_addr.push_back(int'(a_ad));
      log_rd.push_back(a_rwb);
    end
  end

  always @(posedge clk) begin
    if (b_en && !b_rwb) mem_b[b_ad] <= (mem_b[b_ad] & ~b_ben) | (b_di & b_ben);
    if (b_en && b_rwb)  b_do <= mem_b[b_ad];
  end

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_log(input string name);
    int errs;
    errs = 0;
    check({name, "_count"}, 70'(log_addr.size()), 70'(32));
    for (int i = 0; i < 32; i++) begin
      if (i >= log_addr.size()) errs++;
      else if (log_addr[i] != (i % 16) || log_rd[i] != (i >= 16)) errs++;
    end
    check({name, "_order"}, 70'(errs), 70'(0));
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_rd.delete();
  endtask

  // Counts edges until busy drops; optionally pulses start for one cycle after edge number inj.
  task automatic wait_idle(input bit sel, input int inj, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (sel) b_start = (n == inj);
      else     a_start = (n == inj);
      if (!(sel ? b_busy : a_busy)) break;
    end
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b0;
    clear_log();
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  initial begin
    vec_t vt [6];
    int   n;
    int   errs;

    vt[0] = '{32'h1234_5678, 32'hFFFF_FFFF, 4'd5, 1'b1, 1'b0,
              {32'h1234_5678, 32'hFFFF_FFFF, 4'd5, 1'b1, 1'b0}, 1'b0, 32'h0};
    vt[1] = '{32'h0000_0000, 32'h0000_0000, 4'd5, 1'b1, 1'b1,
              {32'h0000_0000, 32'h0000_0000, 4'd5, 1'b1, 1'b1}, 1'b0, 32'h0};
    vt[2] = '{32'hDEAD_BEEF, 32'h0000_FFFF, 4'hA, 1'b0, 1'b1,
              {32'hDEAD_BEEF, 32'h0000_FFFF, 4'hA, 1'b0, 1'b1}, 1'b1, 32'h1234_5678};
    vt[3] = '{32'h0000_00EE, 32'h0000_00FF, 4'd5, 1'b1, 1'b0,
              {32'h0000_00EE, 32'h0000_00FF, 4'd5, 1'b1, 1'b0}, 1'b1, 32'h1234_5678};
    vt[4] = '{32'h0000_0000, 32'h0000_0000, 4'd5, 1'b1, 1'b1,
              {32'h0000_0000, 32'h0000_0000, 4'd5, 1'b1, 1'b1}, 1'b1, 32'h1234_5678};
    vt[5] = '{32'h0000_0000, 32'h0000_0000, 4'd0, 1'b0, 1'b1,
              {32'h0000_0000, 32'h0000_0000, 4'd0, 1'b0, 1'b1}, 1'b1, 32'h1234_56EE};

    rst_a = 1'b0; rst_b = 1'b0; a_start = 1'b0; b_start = 1'b0;
    ca_di = '0; ca_ben = '0; ca_ad = '0; ca_en = 1'b0; ca_rwb = 1'b1;
    cb_di = '0; cb_ben = '0; cb_ad = '0; cb_en = 1'b0; cb_rwb = 1'b1;
    for (int i = 0; i < 16; i++) stuck[i] = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_a_flags", 70'({a_busy, a_done, a_fail, a_faddr}), 70'(7'b100_0000));
    check("rst_a_port",  70'({a_en, a_rwb, a_ad}), 70'({1'b1, 1'b0, 4'd0}));
    check("rst_b_flags", 70'({b_busy, b_done, b_fail}), 70'(3'b000));

    // Auto-init with a clean macro
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    wait_idle(1'b0, 0, n);
    check("init_len", 70'(n), 70'(34));
    check("init_flags", 70'({a_busy, a_done, a_fail}), 70'(3'b010));
    check_log("init_ops");
    errs = 0;
    for (int i = 0; i < 16; i++) if (mem_a[i] !== FILL) errs++;
    check("init_contents", 70'(errs), 70'(0));

    // Single stuck word
    stuck[9] = 1'b1;
    reset_a();
    wait_idle(1'b0, 0, n);
    check("stuck9_len", 70'(n), 70'(34));
    check("stuck9_flags", 70'({a_done, a_fail, a_faddr}), 70'({1'b1, 1'b1, 4'd9}));
    check_log("stuck9_ops");

    // Two stuck words: only the first is reported
    stuck[9] = 1'b0; stuck[3] = 1'b1; stuck[12] = 1'b1;
    reset_a();
    wait_idle(1'b0, 0, n);
    check("stuck2_len", 70'(n), 70'(34));
    check("stuck2_flags", 70'({a_done, a_fail, a_faddr}), 70'({1'b1, 1'b1, 4'd3}));

    // Start clears flags; a second start while busy is ignored
    stuck[3] = 1'b0; stuck[12] = 1'b0;
    clear_log();
    @(negedge clk);
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    check("start_accept", 70'({a_busy, a_done, a_fail}), 70'(3'b100));
    wait_idle(1'b0, 5, n);
    check("start_busy_ignored_len", 70'(n), 70'(34));
    check("start_busy_flags", 70'({a_done, a_fail}), 70'(2'b10));
    check_log("start_busy_ops");

    // Asynchronous reset in the middle of the write pass
    reset_a();
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("mid_wr_port", 70'({a_en, a_rwb, a_ad}), 70'({1'b1, 1'b0, 4'd7}));
    rst_a = 1'b0;
    #1;
    check("async_rst_port", 70'({a_en, a_rwb, a_ad}), 70'({1'b1, 1'b0, 4'd0}));
    check("async_rst_flags", 70'({a_busy, a_done, a_fail}), 70'(3'b100));
    clear_log();
    @(negedge clk);
    rst_a = 1'b1;
    wait_idle(1'b0, 0, n);
    check("rerun_len", 70'(n), 70'(34));
    check("rerun_flags", 70'({a_done, a_fail}), 70'(2'b10));
    check_log("rerun_ops");

    // Pass-through on the idle instance
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cb_di = vt[i].di; cb_ben = vt[i].ben; cb_ad = vt[i].ad;
      cb_en = vt[i].en; cb_rwb = vt[i].rwb;
      #1;
      check($sformatf("pt_bus_%0d", i), {b_di, b_ben, b_ad, b_en, b_rwb}, vt[i].exp_bus);
      if (vt[i].chk_do) check($sformatf("pt_do_%0d", i), 70'(b_cdo), 70'(vt[i].exp_do));
    end
    check("pt_busy", 70'({b_busy, b_done}), 70'(2'b00));

    // Start on the no-verify instance; a start during END is dropped
    @(negedge clk);
    cb_di = 32'hDEAD_BEEF; cb_ben = '0; cb_ad = 4'd9; cb_en = 1'b0; cb_rwb = 1'b1;
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    check("b_start_accept", 70'(b_busy), 70'(1));
    check("b_wr_port", {b_di, b_ben, b_ad, b_en, b_rwb}, {FILL, 32'hFFFF_FFFF, 4'd0, 1'b1, 1'b0});
    wait_idle(1'b1, 16, n);
    check("b_len", 70'(n), 70'(17));
    check("b_flags", 70'({b_busy, b_done, b_fail}), 70'(3'b010));
    @(posedge clk);
    #1;
    check("b_start_in_end_ignored", 70'({b_busy, b_done}), 70'(2'b01));
    check("b_addr5_filled", 70'(mem_b[5]), 70'(FILL));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
